// File: rtl/ips2l_ddrphy_pll_seq_pkg.sv
// Shared types for the DDR PHY PLL reset/lock sequencer.
package ips2l_ddrphy_pll_seq_pkg;

   typedef enum logic [2:0] {
      RST,
      WAIT_LOCK,
      GATE_OPEN,
      RUN,
      LOSS
   } seq_state_e;

   localparam logic [3:0] RETRY_MAX = 4'd15;

endpackage

// File: rtl/ips2l_ddrphy_sync2_v1_0.sv
// Generic two-flop synchronizer, async active-low reset to 0.
module ips2l_ddrphy_sync2_v1_0 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ips2l_ddrphy_ppll_rst_ctrl_v1_0.sv
// PPLL reset/lock sequencer: pulses pll_rst, waits for stable lock, ungates clkoutphy, then releases phy_rst_n.
// Optional lock timeout with retry counting: define IPS2L_DDRPHY_PLL_LOCK_TIMEOUT_EN.
module ips2l_ddrphy_ppll_rst_ctrl_v1_0
   import ips2l_ddrphy_pll_seq_pkg::*;
#(
   parameter int RST_CYCLES          = 16,
   parameter int LOCK_STABLE_CYCLES  = 64,
   parameter int GATE_SETTLE_CYCLES  = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 65535,
   parameter int CNT_W               = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       soft_restart,
   output logic       pll_rst,
   output logic       clkoutphy_gate,
   output logic       phy_rst_n,
   output logic       seq_done,
   output logic       lock_err,
   output logic [3:0] retry_cnt
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(GATE_SETTLE_CYCLES - 1);

   seq_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lock_s;
   logic             timeout;
   logic             pll_rst_d, gate_d, phy_rst_n_d, done_d;

   ips2l_ddrphy_sync2_v1_0 #(.W(1)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

`ifdef IPS2L_DDRPHY_PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   // Separate from the shared counter: the stable count clears on every lock drop.
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;
   logic [3:0]       retry_q;

   assign timeout = (state == WAIT_LOCK) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
         retry_q <= '0;
      end else if (soft_restart) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
         retry_q <= '0;
      end else begin
         tmo_cnt <= (state == WAIT_LOCK && state_nxt == WAIT_LOCK) ? tmo_cnt + 1'b1 : '0;
         if (timeout && state_nxt == RST) begin
            err_q <= 1'b1;
            if (retry_q != RETRY_MAX) retry_q <= retry_q + 1'b1;
         end
      end
   end

   assign lock_err  = err_q;
   assign retry_cnt = retry_q;
`else
   logic unused_tmo;
   assign unused_tmo = (LOCK_TIMEOUT_CYCLES != 0);
   assign timeout    = 1'b0;
   assign lock_err   = 1'b0;
   assign retry_cnt  = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      case (state)
         RST:       if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_s && cnt == STABLE_LAST) state_nxt = GATE_OPEN;
            else if (timeout)                 state_nxt = RST;
            else if (!lock_s)                 cnt_nxt   = '0;
         end
         GATE_OPEN: begin
            if (!lock_s)                 state_nxt = LOSS;
            else if (cnt == SETTLE_LAST) state_nxt = RUN;
         end
         RUN: begin
            cnt_nxt = cnt;
            if (!lock_s) state_nxt = LOSS;
         end
         LOSS:      state_nxt = RST;
         default:   state_nxt = RST;
      endcase
      if (soft_restart) state_nxt = RST;
      // The shared counter restarts on every state entry.
      if (soft_restart || state_nxt != state) cnt_nxt = '0;
   end

   // Outputs decode the next state so they flip on the same edge as the state.
   always_comb begin
      pll_rst_d   = 1'b0;
      gate_d      = 1'b1;
      phy_rst_n_d = 1'b0;
      done_d      = 1'b0;
      case (state_nxt)
         RST:       pll_rst_d = 1'b1;
         GATE_OPEN: gate_d    = 1'b0;
         RUN: begin
            gate_d      = 1'b0;
            phy_rst_n_d = 1'b1;
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pll_rst        <= 1'b1;
         clkoutphy_gate <= 1'b1;
         phy_rst_n      <= 1'b0;
         seq_done       <= 1'b0;
      end else begin
         pll_rst        <= pll_rst_d;
         clkoutphy_gate <= gate_d;
         phy_rst_n      <= phy_rst_n_d;
         seq_done       <= done_d;
      end
   end

endmodule

// File: tb/tb_ips2l_ddrphy_ppll_rst_ctrl_v1_0.sv
// Bench for the PPLL reset sequencer: expected output transitions are queued with their cycle, a monitor pops them.
module tb_ips2l_ddrphy_ppll_rst_ctrl_v1_0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pll_lock = 1'b0;
   logic       soft_restart = 1'b0;
   logic       pll_rst, clkoutphy_gate, phy_rst_n, seq_done, lock_err;
   logic [3:0] retry_cnt;
   logic [8:0] outs;

   typedef struct {
      string      tag;
      int         cyc;
      logic [8:0] val;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] mdl;
   logic [8:0] prev;
   logic       mon_en = 1'b0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign outs = {pll_rst, clkoutphy_gate, phy_rst_n, seq_done, lock_err, retry_cnt};

   ips2l_ddrphy_ppll_rst_ctrl_v1_0 #(
      .RST_CYCLES          (4),
      .LOCK_STABLE_CYCLES  (8),
      .GATE_SETTLE_CYCLES  (3),
      .LOCK_TIMEOUT_CYCLES (100),
      .CNT_W               (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pll_lock       (pll_lock),
      .soft_restart   (soft_restart),
      .pll_rst        (pll_rst),
      .clkoutphy_gate (clkoutphy_gate),
      .phy_rst_n      (phy_rst_n),
      .seq_done       (seq_done),
      .lock_err       (lock_err),
      .retry_cnt      (retry_cnt)
   );

   task automatic chk(input string tag, input int obs, input int want);
      n_chk++;
      if (obs == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, want);
   endtask

   function automatic logic [8:0] vec(input logic pr, input logic g, input logic pn,
                                      input logic sd, input logic le, input logic [3:0] rc);
      return {pr, g, pn, sd, le, rc};
   endfunction

   // Queue only real changes of the modelled output vector.
   task automatic exp_at(input string tag, input int c, input logic [8:0] v);
      if (v != mdl) begin
         exp_q.push_back('{tag, c, v});
         mdl = v;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_pll_rst"},   int'(pll_rst),        1);
      chk({pfx, "_gate"},      int'(clkoutphy_gate), 1);
      chk({pfx, "_phy_rst_n"}, int'(phy_rst_n),      0);
      chk({pfx, "_seq_done"},  int'(seq_done),       0);
      chk({pfx, "_lock_err"},  int'(lock_err),       0);
      chk({pfx, "_retry"},     int'(retry_cnt),      0);
   endtask

   always @(negedge clk) begin
      if (mon_en && outs !== prev) begin
         if (exp_q.size() == 0) begin
            chk("spurious_change", int'(outs), int'(prev));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "_cyc"}, cyc, e.cyc);
            chk({e.tag, "_val"}, int'(outs), int'(e.val));
         end
         prev = outs;
      end
   end

   initial begin
      int c;
      mdl = vec(1, 1, 0, 0, 0, 4'd0);
      #2 rst_n = 1'b0;
      wait_cyc(3);
      chk_reset_vals("rst");
      prev   = outs;
      mon_en = 1'b1;

      // Nominal: release, lock high 10 cycles later
      c = cyc;
      rst_n = 1'b1;
      exp_at("rst_rel", c + 4, vec(0, 1, 0, 0, 0, 4'd0));
      wait_cyc(10);
      c = cyc;
      pll_lock = 1'b1;
      exp_at("nom_gate", c + 10, vec(0, 0, 0, 0, 0, 4'd0));
      exp_at("nom_run",  c + 13, vec(0, 0, 1, 1, 0, 4'd0));
      wait_cyc(16);

      // Lock loss in RUN for 4 cycles
      c = cyc;
      pll_lock = 1'b0;
      exp_at("loss",       c + 3,  vec(0, 1, 0, 0, 0, 4'd0));
      exp_at("loss_rst",   c + 4,  vec(1, 1, 0, 0, 0, 4'd0));
      exp_at("loss_wait",  c + 8,  vec(0, 1, 0, 0, 0, 4'd0));
      exp_at("loss_gate",  c + 16, vec(0, 0, 0, 0, 0, 4'd0));
      exp_at("loss_run",   c + 19, vec(0, 0, 1, 1, 0, 4'd0));
      wait_cyc(4);
      pll_lock = 1'b1;
      wait_cyc(20);

      // Chatter: soft restart, then lock 5 high / 1 low never qualifies
      c = cyc;
      exp_at("chat_rst",  c + 1, vec(1, 1, 0, 0, 0, 4'd0));
      exp_at("chat_wait", c + 5, vec(0, 1, 0, 0, 0, 4'd0));
      for (int i = 0; i < 60; i++) begin
         soft_restart = (i == 0);
         pll_lock     = (i % 6 != 5);
         @(negedge clk);
      end
      pll_lock = 1'b0;
      chk("chatter_gate", int'(clkoutphy_gate), 1);

`ifdef IPS2L_DDRPHY_PLL_LOCK_TIMEOUT_EN
      begin
         int d, t_last;
         d = cyc;
         soft_restart = 1'b1;
         exp_at("tmo_rst",  d + 1, vec(1, 1, 0, 0, 0, 4'd0));
         exp_at("tmo_wait", d + 5, vec(0, 1, 0, 0, 0, 4'd0));
         for (int i = 1; i <= 20; i++) begin
            int t;
            logic [3:0] rc;
            t  = d + 105 + (i - 1) * 104;
            rc = (i > 15) ? 4'd15 : 4'(i);
            exp_at($sformatf("tmo%0d", i),      t,     vec(1, 1, 0, 0, 1, rc));
            exp_at($sformatf("tmo%0d_rel", i),  t + 4, vec(0, 1, 0, 0, 1, rc));
         end
         @(negedge clk);
         soft_restart = 1'b0;
         while (cyc < d + 106) @(negedge clk);
         chk("tmo1_err",   int'(lock_err),  1);
         chk("tmo1_retry", int'(retry_cnt), 1);
         // Restart lands on the edge of the 21st timeout
         t_last = d + 105 + 20 * 104;
         while (cyc < t_last - 1) @(negedge clk);
         chk("sat_retry", int'(retry_cnt), 15);
         chk("sat_err",   int'(lock_err),  1);
         soft_restart = 1'b1;
         exp_at("prio_rst", t_last,     vec(1, 1, 0, 0, 0, 4'd0));
         exp_at("prio_rel", t_last + 4, vec(0, 1, 0, 0, 0, 4'd0));
         @(negedge clk);
         soft_restart = 1'b0;
         chk("prio_err",     int'(lock_err),  0);
         chk("prio_retry",   int'(retry_cnt), 0);
         chk("prio_pll_rst", int'(pll_rst),   1);
         wait_cyc(6);
      end
`else
      wait_cyc(300);
      chk("notmo_err",     int'(lock_err),  0);
      chk("notmo_retry",   int'(retry_cnt), 0);
      chk("notmo_pll_rst", int'(pll_rst),   0);
`endif

      // Reach RUN, then async reset between edges
      c = cyc;
      soft_restart = 1'b1;
      pll_lock     = 1'b1;
      exp_at("r6_rst",  c + 1,  vec(1, 1, 0, 0, 0, 4'd0));
      exp_at("r6_wait", c + 5,  vec(0, 1, 0, 0, 0, 4'd0));
      exp_at("r6_gate", c + 13, vec(0, 0, 0, 0, 0, 4'd0));
      exp_at("r6_run",  c + 16, vec(0, 0, 1, 1, 0, 4'd0));
      @(negedge clk);
      soft_restart = 1'b0;
      wait_cyc(20);
      chk("pending_pre_arst", exp_q.size(), 0);
      chk("run_seq_done", int'(seq_done), 1);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_reset_vals("arst");
      wait_cyc(2);
      mdl    = vec(1, 1, 0, 0, 0, 4'd0);
      prev   = outs;
      mon_en = 1'b1;
      c = cyc;
      rst_n = 1'b1;
      exp_at("rel_wait", c + 4,  vec(0, 1, 0, 0, 0, 4'd0));
      exp_at("rel_gate", c + 12, vec(0, 0, 0, 0, 0, 4'd0));
      exp_at("rel_run",  c + 15, vec(0, 0, 1, 1, 0, 4'd0));
      wait_cyc(20);
      chk("pending_end", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
